// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: drives the instruction memory request, holds the IF/ID
// pipeline register, buffers one word across an ID stall and redirects fetch on branches.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic        IF_VALID,
    output logic [31:0] IF_INSTR,
    output logic [31:0] IF_NPC
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DROP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_npc_q, if_npc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_npc_q, skid_npc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] pc_plus4_s;
    logic        imem_req_s;

    // Wraps modulo 2^32; low address bits pass through untouched.
    assign pc_plus4_s = pc_q + 32'd4;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            if_valid_q   <= 1'b0;
            if_instr_q   <= 32'h0000_0000;
            if_npc_q     <= 32'h0000_0000;
            skid_instr_q <= 32'h0000_0000;
            skid_npc_q   <= 32'h0000_0000;
            tgt_q        <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_npc_q     <= if_npc_d;
            skid_instr_q <= skid_instr_d;
            skid_npc_q   <= skid_npc_d;
            tgt_q        <= tgt_d;
        end
    end

    // Next-state and datapath update; a branch always outranks a stall.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_npc_d     = if_npc_q;
        skid_instr_d = skid_instr_q;
        skid_npc_d   = skid_npc_q;
        tgt_d        = tgt_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                if (BRANCH_TAKEN) begin
                    pc_d       = BRANCH_TARGET;
                    if_valid_d = 1'b0;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_FETCH: begin
                if (BRANCH_TAKEN) begin
                    if_valid_d = 1'b0;
                    if (IMEM_ACK) begin
                        pc_d    = BRANCH_TARGET;
                        state_d = ST_FETCH;
                    end else begin
                        // The request cannot be withdrawn, so remember where to go once it lands.
                        tgt_d   = BRANCH_TARGET;
                        state_d = ST_DROP;
                    end
                end else if (IMEM_ACK) begin
                    if (STALL) begin
                        skid_instr_d = IMEM_RDATA;
                        skid_npc_d   = pc_plus4_s;
                        state_d      = ST_HOLD;
                    end else begin
                        if_instr_d = IMEM_RDATA;
                        if_npc_d   = pc_plus4_s;
                        if_valid_d = 1'b1;
                        pc_d       = pc_plus4_s;
                        state_d    = ST_FETCH;
                    end
                end else begin
                    if (STALL) begin
                        if_valid_d = if_valid_q;
                    end else begin
                        if_valid_d = 1'b0;
                    end
                end
            end
            ST_HOLD: begin
                if (BRANCH_TAKEN) begin
                    pc_d       = BRANCH_TARGET;
                    if_valid_d = 1'b0;
                    state_d    = ST_FETCH;
                end else if (!STALL) begin
                    if_instr_d = skid_instr_q;
                    if_npc_d   = skid_npc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_plus4_s;
                    state_d    = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_DROP: begin
                if_valid_d = 1'b0;
                if (IMEM_ACK) begin
                    pc_d    = BRANCH_TAKEN ? BRANCH_TARGET : tgt_q;
                    state_d = ST_FETCH;
                end else if (BRANCH_TAKEN) begin
                    tgt_d = BRANCH_TARGET;
                end else begin
                    tgt_d = tgt_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                if_valid_d = 1'b0;
            end
        endcase
    end

    // Memory request is a pure decode of the registered state.
    always_comb begin
        imem_req_s = 1'b0;
        case (state_q)
            ST_FETCH: imem_req_s = 1'b1;
            ST_DROP:  imem_req_s = 1'b1;
            ST_IDLE:  imem_req_s = 1'b0;
            ST_HOLD:  imem_req_s = 1'b0;
            default:  imem_req_s = 1'b0;
        endcase
    end

    assign IMEM_REQ  = imem_req_s;
    assign IMEM_ADDR = pc_q;
    assign IF_VALID  = if_valid_q;
    assign IF_INSTR  = if_instr_q;
    assign IF_NPC    = if_npc_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: each driven cycle queues the outputs expected after
// the next rising edge; an independent monitor pops and compares them.
module tb_if_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        STALL = 1'b0;
    logic        BRANCH_TAKEN = 1'b0;
    logic [31:0] BRANCH_TARGET = 32'h0;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK = 1'b0;
    logic [31:0] IMEM_RDATA = 32'h0;
    logic        IF_VALID;
    logic [31:0] IF_INSTR;
    logic [31:0] IF_NPC;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic        chk_if;
        logic [31:0] instr;
        logic [31:0] npc;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    if_fetch_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .BRANCH_TAKEN(BRANCH_TAKEN),
        .BRANCH_TARGET(BRANCH_TARGET), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA), .IF_VALID(IF_VALID),
        .IF_INSTR(IF_INSTR), .IF_NPC(IF_NPC)
    );

    always #5 CLK = ~CLK;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the coming edge.
    task automatic cyc(input logic rst, input logic st, input logic br, input logic [31:0] tgt,
                       input logic ack, input logic [31:0] rd,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                       input logic chk, input logic [31:0] e_instr, input logic [31:0] e_npc,
                       input string nm);
        exp_t e;
        @(negedge CLK);
        RST_N = rst; STALL = st; BRANCH_TAKEN = br; BRANCH_TARGET = tgt;
        IMEM_ACK = ack; IMEM_RDATA = rd;
        e.req = e_req; e.addr = e_addr; e.valid = e_valid; e.chk_if = chk;
        e.instr = e_instr; e.npc = e_npc; e.name = nm;
        sb_q.push_back(e);
    endtask

    // Monitor: compare whatever the DUT presents just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                cmp(e.name, "req", {31'h0, IMEM_REQ}, {31'h0, e.req});
                cmp(e.name, "addr", IMEM_ADDR, e.addr);
                cmp(e.name, "valid", {31'h0, IF_VALID}, {31'h0, e.valid});
                if (e.chk_if) begin
                    cmp(e.name, "instr", IF_INSTR, e.instr);
                    cmp(e.name, "npc", IF_NPC, e.npc);
                end
            end
        end
    end

    initial begin
        //   rst st br tgt           ack rdata          req addr          vld chk instr          npc            name
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 32'h0,        32'h0,        "reset");
        cyc(0, 1, 1, 32'h123,      1, 32'hDEAD,     0, 32'h0,        0, 1, 32'h0,        32'h0,        "reset_ign");
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 1, 32'h0,        32'h0,        "first_req");
        cyc(1, 0, 0, 32'h0,        1, 32'h0,        1, 32'h4,        1, 1, 32'h0,        32'h4,        "seq0");
        cyc(1, 0, 0, 32'h0,        1, 32'h1,        1, 32'h8,        1, 1, 32'h1,        32'h8,        "seq1");
        cyc(1, 0, 0, 32'h0,        1, 32'h2,        1, 32'hC,        1, 1, 32'h2,        32'hC,        "seq2");
        cyc(1, 1, 0, 32'h0,        1, 32'hAAAA0001, 0, 32'hC,        1, 1, 32'h2,        32'hC,        "stall1");
        cyc(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'hC,        1, 1, 32'h2,        32'hC,        "stall2");
        cyc(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'hC,        1, 1, 32'h2,        32'hC,        "stall3");
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       1, 1, 32'hAAAA0001, 32'h10,       "skid_out");
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       0, 0, 32'h0,        32'h0,        "bubble");
        cyc(1, 0, 1, 32'h200,      0, 32'h0,        1, 32'h10,       0, 0, 32'h0,        32'h0,        "drop_enter");
        cyc(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       0, 0, 32'h0,        32'h0,        "drop_wait");
        cyc(1, 0, 0, 32'h0,        1, 32'hBAD0BAD0, 1, 32'h200,      0, 1, 32'hAAAA0001, 32'h10,       "drop_ack");
        cyc(1, 0, 0, 32'h0,        1, 32'h11111111, 1, 32'h204,      1, 1, 32'h11111111, 32'h204,      "post_drop");
        cyc(1, 0, 1, 32'h300,      0, 32'h0,        1, 32'h204,      0, 0, 32'h0,        32'h0,        "br300");
        cyc(1, 0, 1, 32'h400,      0, 32'h0,        1, 32'h204,      0, 0, 32'h0,        32'h0,        "br400");
        cyc(1, 0, 0, 32'h0,        1, 32'hBAD1,     1, 32'h400,      0, 1, 32'h11111111, 32'h204,      "latest_win");
        cyc(1, 0, 1, 32'h600,      0, 32'h0,        1, 32'h400,      0, 0, 32'h0,        32'h0,        "br600");
        cyc(1, 0, 1, 32'h700,      1, 32'hBAD2,     1, 32'h700,      0, 1, 32'h11111111, 32'h204,      "br_ack_cyc");
        cyc(1, 0, 0, 32'h0,        1, 32'h22222222, 1, 32'h704,      1, 1, 32'h22222222, 32'h704,      "fetch704");
        cyc(1, 1, 0, 32'h0,        1, 32'h33333333, 0, 32'h704,      1, 1, 32'h22222222, 32'h704,      "hold2");
        cyc(1, 1, 1, 32'h800,      0, 32'h0,        1, 32'h800,      0, 1, 32'h22222222, 32'h704,      "hold_br_st");
        cyc(1, 0, 0, 32'h0,        1, 32'h44444444, 1, 32'h804,      1, 1, 32'h44444444, 32'h804,      "skid_gone");
        cyc(1, 0, 1, 32'hFFFFFFFC, 1, 32'h55555555, 1, 32'hFFFFFFFC, 0, 1, 32'h44444444, 32'h804,      "fetch_br");
        cyc(1, 0, 0, 32'h0,        1, 32'h66666666, 1, 32'h0,        1, 1, 32'h66666666, 32'h0,        "wrap");
        cyc(1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        1, 1, 32'h66666666, 32'h0,        "stall_noack");
        cyc(1, 1, 1, 32'h900,      0, 32'h0,        1, 32'h0,        0, 0, 32'h0,        32'h0,        "flush_stall");
        cyc(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 32'h0,        32'h0,        "rst_drop");
        cyc(1, 0, 0, 32'h0,        1, 32'hBAD3,     1, 32'h0,        0, 1, 32'h0,        32'h0,        "late_ack");
        cyc(1, 0, 0, 32'h0,        1, 32'h77,       1, 32'h4,        1, 1, 32'h77,       32'h4,        "restart");
        @(negedge CLK);
        IMEM_ACK = 1'b0; BRANCH_TAKEN = 1'b0; STALL = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
